// File: rtl/nios_ram_port_ctrl.sv
// Shares one single-port 8-bit RAM between the NES core and a NIOS Avalon slave.
// Define AUTO_INC_EN to step the ADDR register after every completed NIOS access.
module nios_ram_port_ctrl #(
  parameter int AW       = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    address,
  input  logic          write,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  input  logic          nes_req,
  input  logic          nes_we,
  input  logic [AW-1:0] nes_addr,
  input  logic [7:0]    nes_wdata,
  output logic          nes_ack,
  output logic [7:0]    nes_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  input  logic [7:0]    ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DONE
  } state_t;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);
  localparam logic [1:0] LAT_END  = 2'(RD_LAT - 1);

  state_t state;
  state_t state_nx;

  logic [AW-1:0] addr_reg;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_reg;
  logic [7:0]    wdata_q;
  logic [7:0]    rdata_reg;
  logic [7:0]    wait_cnt;
  logic [1:0]    lat_cnt;

  logic busy;
  logic done;
  logic nios_pend;
  logic cmd_we;
  logic own_nes;

  logic in_idle;
  logic nes_win;
  logic nios_win;
  logic lat_last;
  logic nios_fin;
  logic go;
  logic unused_wd;

  assign unused_wd = ^writedata[31:AW];

  // NIOS is forced in once the NES has taken MAX_WAIT grants past it
  assign in_idle  = state == IDLE;
  assign nes_win  = nes_req &&
                    !(nios_pend && wait_cnt == WAIT_MAX);
  assign nios_win = !nes_win && nios_pend;
  assign lat_last = lat_cnt == LAT_END;
  assign nios_fin = state == DONE && !own_nes;
  assign go       = write && address == 2'd2 &&
                    writedata[0] && !busy;

  assign ram_we  = state == WR;
  assign nes_ack = state == DONE && own_nes;

  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (in_idle) begin
      unique case (1'b1)
        nes_win: begin
          ram_addr  = nes_addr;
          ram_wdata = nes_wdata;
        end
        nios_win: begin
          ram_addr  = addr_reg;
          ram_wdata = wdata_reg;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          nes_win:  state_nx = nes_we ? WR : RD;
          nios_win: state_nx = cmd_we ? WR : RD;
          default:  state_nx = IDLE;
        endcase
      end
      WR:      state_nx = DONE;
      RD:      state_nx = lat_last ? DONE : RD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // The grant cycle freezes address, data and owner for the access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      own_nes <= 1'b0;
      lat_cnt <= '0;
    end else if (in_idle) begin
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
      own_nes <= nes_win;
      lat_cnt <= '0;
    end else if (state == RD) begin
      lat_cnt <= lat_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nes_rdata <= '0;
      rdata_reg <= '0;
    end else if (state == RD && lat_last) begin
      if (own_nes) nes_rdata <= ram_rdata;
      else         rdata_reg <= ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nios_pend <= 1'b0;
      cmd_we    <= 1'b0;
    end else begin
      if (nios_fin) begin
        busy      <= 1'b0;
        done      <= 1'b1;
        nios_pend <= 1'b0;
`ifdef AUTO_INC_EN
        addr_reg  <= addr_reg + AW'(1);
`endif
      end
      if (write) begin
        unique case (address)
          2'd0:    addr_reg  <= writedata[AW-1:0];
          2'd1:    wdata_reg <= writedata[7:0];
          default: ;
        endcase
      end
      if (go) begin
        busy      <= 1'b1;
        nios_pend <= 1'b1;
        done      <= 1'b0;
        cmd_we    <= writedata[1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!nios_pend || (in_idle && nios_win)) begin
      wait_cnt <= '0;
    end else if (in_idle && nes_win && wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      unique case (address)
        2'd0:    readdata <= 32'(addr_reg);
        2'd1:    readdata <= {24'b0, wdata_reg};
        2'd2:    readdata <= '0;
        default: readdata <= {22'b0, done, busy, rdata_reg};
      endcase
    end
  end

endmodule
